// File: rtl/prog_counter_pkg.sv
// Shared constants and next-count selection
// for the programmable modulo counter.
package prog_counter_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic                 term;
    logic [CNT_MAX_W-1:0] nxt;
  } step_t;

  // Operands are zero-extended by the caller; cnt+1 and cnt-1
  // are only taken when no wrap can occur.
  function automatic step_t next_count(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic [CNT_MAX_W-1:0] mod,
    input logic                 up
  );
    step_t r;
    if (up == DIR_UP) begin
      r.term = (cnt >= mod);
      r.nxt  = r.term ? '0 : cnt + 1'b1;
    end else begin
      r.term = (cnt == '0);
      r.nxt  = r.term ? mod : cnt - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: ticks once every
// (prescale+1) enabled, non-held cycles.
module count_prescaler
  import prog_counter_pkg::*;
#(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             hold,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic             hit;

  assign hit  = (pre_cnt_q == prescale);
  assign tick = enable & hit & ~hold;

  // pre_cnt above prescale rolls through 2^PRE_W-1 back to 0.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (enable && !hold) begin
      pre_cnt_d = hit ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/prog_modulo_counter.sv
// Runtime-programmable up/down modulo counter
// with load, clear, prescaler, wrap pulse and one-shot.
module prog_modulo_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic             dir,
  input  logic             oneshot,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             wrap_o,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             done_q;
  logic             done_d;
  logic             tick;
  step_t            st;

  count_prescaler #(
    .PRE_W(PRE_W)
  ) u_pre (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .hold    (done_q),
    .restart (clr | load),
    .prescale(prescale),
    .tick    (tick)
  );

  always_comb begin
    st = next_count(CNT_MAX_W'(count_q),
                    CNT_MAX_W'(modulus),
                    dir);
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    priority case (1'b1)
      clr: begin
        count_d = '0;
        done_d  = 1'b0;
      end
      load: begin
        count_d = load_val;
        done_d  = 1'b0;
      end
      tick: begin
        wrap_d = st.term;
        // One-shot terminal freezes count; tick is gated by done.
        if (st.term && (oneshot == MODE_ONESHOT)) begin
          done_d = 1'b1;
        end else begin
          count_d = WIDTH'(st.nxt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count  = count_q;
  assign wrap_o = wrap_q;
  assign done   = done_q;

endmodule

// File: tb/tb_prog_modulo_counter.sv
// Directed self-checking bench for
// prog_modulo_counter.
module tb_prog_modulo_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] modulus = '0;
  logic       dir = 1'b1;
  logic       oneshot = 1'b0;
  logic [3:0] prescale = '0;
  logic [7:0] count;
  logic       wrap_o;
  logic       done;

  int checks = 0;
  int failures = 0;

  prog_modulo_counter #(
    .WIDTH(8),
    .PRE_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .modulus (modulus),
    .dir     (dir),
    .oneshot (oneshot),
    .prescale(prescale),
    .count   (count),
    .wrap_o  (wrap_o),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    clr = 1'b0;
    load = 1'b0;
    load_val = '0;
    modulus = '0;
    dir = 1'b1;
    oneshot = 1'b0;
    prescale = '0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({count, wrap_o, done} !== 10'b0) begin
      failures++;
      $display("FAIL reset got c=%0d w=%0b d=%0b exp c=0 w=0 d=0",
               count, wrap_o, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_free_run();
    logic [7:0] ec [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic       ew [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    test_reset();
    modulus = 8'd5;
    dir = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      checks++;
      if ({count, wrap_o, done} !== {ec[i], ew[i], 1'b0}) begin
        failures++;
        $display("FAIL free_run[%0d] got c=%0d w=%0b d=%0b exp c=%0d w=%0b d=0",
                 i, count, wrap_o, done, ec[i], ew[i]);
      end
    end
    cyc();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({count, wrap_o} !== 9'b0) begin
      failures++;
      $display("FAIL async_reset got c=%0d w=%0b exp c=0 w=0",
               count, wrap_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_down_prescale();
    logic [7:0] sq [6] = '{8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic [7:0] ecs [5] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd2};
    logic       ew;
    test_reset();
    modulus = 8'd3;
    dir = 1'b0;
    prescale = 4'd2;
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      ew = (i == 3) || (i == 15);
      checks++;
      if ({count, wrap_o} !== {sq[i/3], ew}) begin
        failures++;
        $display("FAIL down_pre[%0d] got c=%0d w=%0b exp c=%0d w=%0b",
                 i, count, wrap_o, sq[i/3], ew);
      end
    end
    for (int i = 0; i < 5; i++) begin
      enable = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if ({count, wrap_o} !== {ecs[i], 1'b0}) begin
        failures++;
        $display("FAIL stall[%0d] got c=%0d w=%0b exp c=%0d w=0",
                 i, count, wrap_o, ecs[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] ec;
    logic       ew;
    logic       ed;
    test_reset();
    modulus = 8'd4;
    dir = 1'b1;
    oneshot = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      ec = (i < 4) ? 8'(i) : 8'd4;
      ew = (i == 5);
      ed = (i >= 5);
      checks++;
      if ({count, wrap_o, done} !== {ec, ew, ed}) begin
        failures++;
        $display("FAIL oneshot[%0d] got c=%0d w=%0b d=%0b exp c=%0d w=%0b d=%0b",
                 i, count, wrap_o, done, ec, ew, ed);
      end
    end
    load_val = 8'd2;
    load = 1'b1;
    cyc();
    checks++;
    if ({count, wrap_o, done} !== {8'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_load got c=%0d w=%0b d=%0b exp c=2 w=0 d=0",
               count, wrap_o, done);
    end
    load = 1'b0;
    cyc();
    checks++;
    if ({count, done} !== {8'd3, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_resume got c=%0d d=%0b exp c=3 d=0",
               count, done);
    end
  endtask

  task automatic test_priority();
    test_reset();
    modulus = 8'd20;
    dir = 1'b1;
    enable = 1'b1;
    cyc();
    clr = 1'b1;
    load = 1'b1;
    load_val = 8'd7;
    cyc();
    checks++;
    if ({count, wrap_o, done} !== 10'b0) begin
      failures++;
      $display("FAIL prio_clr got c=%0d w=%0b d=%0b exp c=0 w=0 d=0",
               count, wrap_o, done);
    end
    clr = 1'b0;
    cyc();
    checks++;
    if ({count, wrap_o} !== {8'd7, 1'b0}) begin
      failures++;
      $display("FAIL prio_load got c=%0d w=%0b exp c=7 w=0",
               count, wrap_o);
    end
    load = 1'b0;
    cyc();
    checks++;
    if (count !== 8'd8) begin
      failures++;
      $display("FAIL prio_after got c=%0d exp c=8", count);
    end
  endtask

  task automatic test_modulus_change();
    logic [7:0] ec [5] = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       ew [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    test_reset();
    modulus = 8'd12;
    dir = 1'b1;
    enable = 1'b1;
    load_val = 8'd9;
    load = 1'b1;
    cyc();
    checks++;
    if (count !== 8'd9) begin
      failures++;
      $display("FAIL mod_load got c=%0d exp c=9", count);
    end
    load = 1'b0;
    modulus = 8'd6;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) modulus = 8'd0;
      cyc();
      checks++;
      if ({count, wrap_o} !== {ec[i], ew[i]}) begin
        failures++;
        $display("FAIL mod_chg[%0d] got c=%0d w=%0b exp c=%0d w=%0b",
                 i, count, wrap_o, ec[i], ew[i]);
      end
    end
  endtask

  task automatic test_load_above();
    test_reset();
    modulus = 8'd5;
    dir = 1'b0;
    enable = 1'b1;
    load_val = 8'd9;
    load = 1'b1;
    cyc();
    load = 1'b0;
    for (int k = 8; k >= 0; k--) begin
      cyc();
      checks++;
      if ({count, wrap_o} !== {8'(k), 1'b0}) begin
        failures++;
        $display("FAIL above_down[%0d] got c=%0d w=%0b exp c=%0d w=0",
                 k, count, wrap_o, k);
      end
    end
    cyc();
    checks++;
    if ({count, wrap_o} !== {8'd5, 1'b1}) begin
      failures++;
      $display("FAIL above_wrap got c=%0d w=%0b exp c=5 w=1",
               count, wrap_o);
    end
    dir = 1'b1;
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    checks++;
    if ({count, wrap_o} !== {8'd0, 1'b1}) begin
      failures++;
      $display("FAIL above_up got c=%0d w=%0b exp c=0 w=1",
               count, wrap_o);
    end
  endtask

  initial begin
    test_free_run();
    test_down_prescale();
    test_oneshot();
    test_priority();
    test_modulus_change();
    test_load_above();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
